// File: rtl/vsmac_ctrl_if.sv
// vsmac_ctrl_if: command, operand-read, MAC-drive and result handshake
// bundle for vsmac_ctrl. slave = the sequencer, master = its environment.
//
// Signals:
//   start/base_addr/pause      pass command from the system
//   busy/done                  pass status back to the system
//   rd_en/rd_addr              operand read strobe and address
//   mac_clear/mac_enable       vsmac reset and enable
//   mac_out                    vsmac output bus
//   result/result_valid/ready  captured result, valid/ready handshake
interface vsmac_ctrl_if #(
  parameter int SIZE   = 6,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
);
  logic                    start;
  logic [ADDR_W-1:0]       base_addr;
  logic                    pause;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    mac_clear;
  logic                    mac_enable;
  logic [WIDTH*SIZE-1:0]   mac_out;
  logic [WIDTH*SIZE-1:0]   result;
  logic                    result_valid;
  logic                    result_ready;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start,
    input  base_addr,
    input  pause,
    input  mac_out,
    input  result_ready,
    output rd_en,
    output rd_addr,
    output mac_clear,
    output mac_enable,
    output result,
    output result_valid,
    output busy,
    output done
  );

  modport master (
    output start,
    output base_addr,
    output pause,
    output mac_out,
    output result_ready,
    input  rd_en,
    input  rd_addr,
    input  mac_clear,
    input  mac_enable,
    input  result,
    input  result_valid,
    input  busy,
    input  done
  );
endinterface

// File: rtl/vsmac_ctrl.sv
// vsmac_ctrl: sequences one vsmac pass (clear, operand stream, drain,
// capture) and offers the SIZE-lane result on a valid/ready handshake.
//
// Ports:
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-high; aborts any pass in flight
//   bus    vsmac_ctrl_if.slave (command, operand reads, MAC drive,
//          result handshake)
module vsmac_ctrl #(
  parameter int SIZE          = 6,
  parameter int WIDTH         = 8,
  parameter int ACCUMULATIONS = 3,
  parameter int ADDR_W        = 8,
  parameter int DRAIN_CYCLES  = 2
) (
  input  logic         clk,
  input  logic         reset,
  vsmac_ctrl_if.slave  bus
);

  localparam int RW = WIDTH * SIZE;
  localparam int KW =
    (ACCUMULATIONS > 1) ? $clog2(ACCUMULATIONS) : 1;
  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [KW-1:0] K_LAST =
    KW'(ACCUMULATIONS - 1);
  localparam logic [DW-1:0] D_LAST =
    DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [KW-1:0]     k;
  logic [DW-1:0]     dcnt;
  logic [ADDR_W-1:0] base_q;
  logic              mac_en_q;
  logic [RW-1:0]     result_q;
  logic              done_q;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              mac_clear;
  logic              busy;
  logic              result_valid;

  wire start_ok  = (state == S_IDLE) && bus.start;
  wire issue_en  = (state == S_RUN) && !bus.pause;
  wire last_iss  = issue_en && (k == K_LAST);
  wire last_drn  = (state == S_DRAIN) && (dcnt == D_LAST);
  wire accept    = (state == S_OUT) && bus.result_ready;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.start)        state_nx = S_CLEAR;
      S_CLEAR:                       state_nx = S_RUN;
      S_RUN:   if (last_iss)         state_nx = S_DRAIN;
      S_DRAIN: if (last_drn)         state_nx = S_OUT;
      S_OUT:   if (bus.result_ready) state_nx = S_IDLE;
      default:                       state_nx = S_IDLE;
    endcase
  end

  // output decode
  always_comb begin
    rd_en        = 1'b0;
    mac_clear    = reset;
    busy         = 1'b1;
    result_valid = 1'b0;
    unique case (state)
      S_IDLE:  busy         = 1'b0;
      S_CLEAR: mac_clear    = 1'b1;
      S_RUN:   rd_en        = !bus.pause && !reset;
      S_DRAIN: ;
      S_OUT:   result_valid = 1'b1;
      default: busy         = 1'b0;
    endcase
    rd_addr = rd_en ? base_q + ADDR_W'(k) : '0;
  end

  // operand index; wraps to 0 after the final issue
  always_ff @(posedge clk) begin
    if (reset) begin
      k <= '0;
    end else if (state == S_CLEAR) begin
      k <= '0;
    end else if (issue_en) begin
      k <= last_iss ? '0 : k + 1'b1;
    end
  end

  // drain counter runs only while in DRAIN
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt <= '0;
    end else if (state == S_DRAIN) begin
      dcnt <= last_drn ? '0 : dcnt + 1'b1;
    end else begin
      dcnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
    end else if (start_ok) begin
      base_q <= bus.base_addr;
    end
  end

  // read data returns one cycle after issue, so enable trails rd_en
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_en_q <= 1'b0;
    end else begin
      mac_en_q <= rd_en;
    end
  end

  // capture after the vsmac output register has settled
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else if (last_drn) begin
      result_q <= bus.mac_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= accept;
    end
  end

  assign bus.rd_en        = rd_en;
  assign bus.rd_addr      = rd_addr;
  assign bus.mac_clear    = mac_clear;
  assign bus.mac_enable   = mac_en_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid;
  assign bus.busy         = busy;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_vsmac_ctrl.sv
// tb_vsmac_ctrl: drives vsmac_ctrl against operand memories and a
// behavioural vsmac; results are checked through a scoreboard queue.
module tb_vsmac_ctrl;

  localparam int SIZE   = 6;
  localparam int WIDTH  = 8;
  localparam int ACC    = 3;
  localparam int ADDR_W = 8;
  localparam int DRAIN  = 2;
  localparam int RW     = SIZE * WIDTH;

  logic clk;
  logic reset;

  vsmac_ctrl_if #(
    .SIZE(SIZE), .WIDTH(WIDTH), .ADDR_W(ADDR_W)
  ) bus ();

  vsmac_ctrl #(
    .SIZE(SIZE),
    .WIDTH(WIDTH),
    .ACCUMULATIONS(ACC),
    .ADDR_W(ADDR_W),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0]    wmem [256];
  logic [WIDTH-1:0] smem [256];
  logic [RW-1:0]    a_q;
  logic [WIDTH-1:0] b_q;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    mac_out_r;

  assign bus.mac_out = mac_out_r;

  // 1-cycle-latency operand memories
  always @(posedge clk) begin
    if (bus.rd_en) begin
      a_q <= wmem[bus.rd_addr];
      b_q <= smem[bus.rd_addr];
    end
  end

  // behavioural vsmac: posedge accumulate, negedge output register
  always @(posedge clk) begin
    if (bus.mac_clear) begin
      acc <= '0;
    end else if (bus.mac_enable) begin
      for (int l = 0; l < SIZE; l++) begin
        acc[l*WIDTH +: WIDTH] <=
          acc[l*WIDTH +: WIDTH] +
          WIDTH'(a_q[l*WIDTH +: WIDTH] * b_q);
      end
    end
  end

  always @(negedge clk) mac_out_r <= acc;

  int n_chk  = 0;
  int n_fail = 0;
  logic [RW-1:0] sb_q [$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] golden(input logic [7:0] base);
    logic [RW-1:0] s;
    logic [7:0]    a;
    logic [7:0]    prod;
    s = '0;
    for (int k = 0; k < ACC; k++) begin
      a = base + 8'(k);
      for (int l = 0; l < SIZE; l++) begin
        prod = 8'(wmem[a][l*WIDTH +: WIDTH] * smem[a]);
        s[l*WIDTH +: WIDTH] = s[l*WIDTH +: WIDTH] + prod;
      end
    end
    return s;
  endfunction

  // one pass; cycle 0 is the cycle start is presented
  task automatic run_pass(input logic [7:0] base,
                          input int pcyc,
                          input int hold,
                          input bit poke);
    int   vcnt, nissue, first_v, acc_c, done_c;
    logic exp_rd, prev_rd;
    logic [7:0] ea;
    logic [RW-1:0] held;
    sb_q.push_back(golden(base));
    vcnt = 0; nissue = 0; first_v = -1;
    acc_c = -1; done_c = -1; prev_rd = 1'b0;
    held = '0;
    for (int c = 0; c < 64 && done_c < 0; c++) begin
      @(posedge clk); #1;
      bus.start        = (c == 0) ||
                         (poke && vcnt > 0 && vcnt < hold);
      bus.base_addr    = (c == 0) ? base : 8'h55;
      bus.pause        = (c == pcyc);
      bus.result_ready = (vcnt >= hold);
      @(negedge clk);
      exp_rd = (c >= 2) && (c != pcyc) && (nissue < ACC);
      chk("rd_en", 64'(bus.rd_en), 64'(exp_rd));
      if (exp_rd) begin
        ea = base + 8'(nissue);
        chk("rd_addr", 64'(bus.rd_addr), 64'(ea));
        nissue++;
      end
      chk("mac_enable", 64'(bus.mac_enable), 64'(prev_rd));
      prev_rd = exp_rd;
      if (c == 1) begin
        chk("clear", 64'(bus.mac_clear), 64'd1);
        chk("busy", 64'(bus.busy), 64'd1);
      end
      if (bus.result_valid) begin
        if (first_v < 0) begin
          first_v = c;
          held = bus.result;
        end else begin
          chk("result_hold", 64'(bus.result), 64'(held));
        end
        vcnt++;
        if (bus.result_ready && acc_c < 0) begin
          acc_c = c;
          if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
          else chk("result", 64'(bus.result), 64'(sb_q.pop_front()));
        end
      end else if (first_v >= 0 && acc_c < 0) begin
        chk("valid_drop", 64'd0, 64'd1);
      end
      if (bus.done) done_c = c;
    end
    chk("valid_lat", 64'(first_v),
        64'(ACC + DRAIN + 2 + ((pcyc >= 0) ? 1 : 0)));
    chk("accept_cyc", 64'(acc_c), 64'(first_v + hold));
    chk("done_cyc", 64'(done_c), 64'(acc_c + 1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_done", 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [63:0] tmp;
    for (int i = 0; i < 256; i++) begin
      tmp = {$urandom(), $urandom()};
      wmem[i] = tmp[RW-1:0];
      smem[i] = 8'($urandom());
    end
    reset = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.pause = 1'b0;
    bus.result_ready = 1'b1;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_clear", 64'(bus.mac_clear), 64'd1);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
      chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
      chk("rst_mac_en", 64'(bus.mac_enable), 64'd0);
      chk("rst_valid", 64'(bus.result_valid), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run_pass(8'h10, -1, 0, 1'b0);
    run_pass(8'h10, 3, 0, 1'b0);
    run_pass(8'h10, -1, 5, 1'b1);
    run_pass(8'hFE, -1, 0, 1'b0);

    // reset during RUN with k=1
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.base_addr = 8'h40;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_clear", 64'(bus.mac_clear), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_rd_en", 64'(bus.rd_en), 64'd0);
    chk("abort_mac_en", 64'(bus.mac_enable), 64'd0);
    chk("abort_valid", 64'(bus.result_valid), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(bus.done), 64'd0);
    end
    run_pass(8'h80, -1, 0, 1'b0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
